// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: time-shares one external FullAdder cell, LSB first,
// one bit per clock, with valid/ready request and response ports.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_c,
  input  logic             fa_sum,
  input  logic             fa_carry,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             overflow,
  output logic             busy
);
  // Handshakes: a transfer happens on a rising edge where valid && ready are both
  // high; ready never depends on valid, and result_valid holds until it is taken.
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] result_sr_q, result_sr_d;
  logic             cout_q, cout_d;
  logic             overflow_q, overflow_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      carry_q     <= 1'b0;
      a_sr_q      <= '0;
      b_sr_q      <= '0;
      result_sr_q <= '0;
      cout_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      carry_q     <= carry_d;
      a_sr_q      <= a_sr_d;
      b_sr_q      <= b_sr_d;
      result_sr_q <= result_sr_d;
      cout_q      <= cout_d;
      overflow_q  <= overflow_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    carry_d      = carry_q;
    a_sr_d       = a_sr_q;
    b_sr_d       = b_sr_q;
    result_sr_d  = result_sr_q;
    cout_d       = cout_q;
    overflow_d   = overflow_q;
    start_ready  = 1'b0;
    result_valid = 1'b0;
    busy         = 1'b0;
    fa_a         = 1'b0;
    fa_b         = 1'b0;
    fa_c         = 1'b0;
    case (state_q)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = cin;
          count_d = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        busy        = 1'b1;
        fa_a        = a_sr_q[0];
        fa_b        = b_sr_q[0];
        fa_c        = carry_q;
        result_sr_d = {fa_sum, result_sr_q[WIDTH-1:1]};
        a_sr_d      = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d      = {1'b0, b_sr_q[WIDTH-1:1]};
        carry_d     = fa_carry;
        count_d     = count_q + CW'(1);
        if (count_q == LAST) begin
          // Signed overflow: carry into the MSB differs from carry out of it.
          cout_d     = fa_carry;
          overflow_d = carry_q ^ fa_carry;
          count_d    = '0;
          state_d    = DONE;
        end
      end
      DONE: begin
        busy         = 1'b1;
        result_valid = 1'b1;
        if (result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign result   = result_sr_q;
  assign cout     = cout_q;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed cases plus random operands
// checked against an arithmetic reference model through a response scoreboard.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_valid = 1'b0;
  logic         start_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic         fa_a, fa_b, fa_c, fa_sum, fa_carry;
  logic         result_valid;
  logic         result_ready = 1'b0;
  logic [W-1:0] result;
  logic         cout, overflow, busy;
  logic [1:0]   fa_tot;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit rr_rand = 0;
  logic [W+1:0] exp_q[$];

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
    .a(a), .b(b), .cin(cin), .fa_a(fa_a), .fa_b(fa_b), .fa_c(fa_c),
    .fa_sum(fa_sum), .fa_carry(fa_carry), .result_valid(result_valid),
    .result_ready(result_ready), .result(result), .cout(cout),
    .overflow(overflow), .busy(busy)
  );

  // External FullAdder cell
  assign fa_tot   = {1'b0, fa_a} + {1'b0, fa_b} + {1'b0, fa_c};
  assign fa_sum   = fa_tot[0];
  assign fa_carry = fa_tot[1];

  // clock/reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: {result, cout, overflow} from plain unsigned/signed arithmetic.
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic c);
    int u, s;
    logic [W-1:0] r;
    u = int'(x) + int'(y) + int'(c);
    s = int'($signed(x)) + int'($signed(y)) + int'(c);
    r = W'(u);
    model = {r, u >= (1 << W), (s > (1 << (W - 1)) - 1) || (s < -(1 << (W - 1)))};
  endfunction

  // scoreboard: pop one expectation per response handshake
  always @(negedge clk) begin
    logic [W+1:0] e;
    if (!rst && result_valid && result_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("result", 32'(result), 32'(e[W+1:2]));
        check("cout", 32'(cout), 32'(e[1]));
        check("overflow", 32'(overflow), 32'(e[0]));
      end
    end
  end

  // driver tasks: inputs change #1 after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (rr_rand) result_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                      input bit keep_valid, output int acc_cyc);
    a = x;
    b = y;
    cin = c;
    start_valid = 1'b1;
    acc_cyc = -1;
    for (int i = 0; i < 200; i++) begin
      if (start_ready) begin
        acc_cyc = cyc;
        exp_q.push_back(model(x, y, c));
        tick();
        break;
      end
      tick();
    end
    if (acc_cyc < 0) check("accept_timeout", 32'd1, 32'd0);
    start_valid = keep_valid;
    a = W'($urandom);
    b = W'($urandom);
    cin = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_valid();
    for (int i = 0; i < 40; i++) begin
      if (result_valid) return;
      tick();
    end
    check("valid_timeout", 32'd1, 32'd0);
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
    check("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int acc;
    int acc_prev;
    logic [W-1:0] sa[4];
    logic [W-1:0] sb[4];
    logic [W-1:0] x, y;
    logic         c;

    tick(); tick(); tick();
    rst = 1'b0;
    check("rst_start_ready", 32'(start_ready), 32'd1);
    check("rst_result_valid", 32'(result_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_cout_ovf", 32'({cout, overflow}), 32'd0);
    check("rst_fa", 32'({fa_a, fa_b, fa_c}), 32'd0);

    // 0x5A + 0x33 with latency measurement
    result_ready = 1'b1;
    send(8'h5A, 8'h33, 1'b0, 1'b0, acc);
    wait_valid();
    check("latency", 32'(cyc - acc), 32'(W + 1));
    drain();
    send(8'hFF, 8'h01, 1'b0, 1'b0, acc);
    send(8'h7F, 8'h00, 1'b1, 1'b0, acc);
    drain();

    // backpressure with an ignored request pulse while DONE
    result_ready = 1'b0;
    send(8'h10, 8'h20, 1'b0, 1'b0, acc);
    wait_valid();
    for (int j = 0; j < 5; j++) begin
      check("bp_valid", 32'(result_valid), 32'd1);
      check("bp_result", 32'(result), 32'h30);
      check("bp_start_ready", 32'(start_ready), 32'd0);
      start_valid = (j == 1);
      a = 8'h01;
      b = 8'h00;
      tick();
    end
    start_valid = 1'b0;
    result_ready = 1'b1;
    tick();
    check("bp_released", 32'(result_valid), 32'd0);
    tick();
    check("bp_no_ghost", 32'(busy), 32'd0);
    drain();

    // reset while count==3; previous op leaves cout/overflow set
    send(8'h80, 8'h80, 1'b0, 1'b0, acc);
    drain();
    send(8'hAA, 8'h55, 1'b0, 1'b0, acc);
    tick(); tick(); tick();
    rst = 1'b1;
    exp_q.delete();
    tick();
    rst = 1'b0;
    check("mid_rst_start_ready", 32'(start_ready), 32'd1);
    check("mid_rst_valid", 32'(result_valid), 32'd0);
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_cout_ovf", 32'({cout, overflow}), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    send(8'h01, 8'h02, 1'b0, 1'b0, acc);
    drain();

    // streaming with start_valid held high
    sa = '{8'h00, 8'h80, 8'h0F, 8'h7F};
    sb = '{8'h00, 8'h80, 8'hF1, 8'h01};
    acc_prev = -1;
    for (int k = 0; k < 4; k++) begin
      send(sa[k], sb[k], 1'b0, k != 3, acc);
      if (k > 0) check("stream_spacing", 32'(acc - acc_prev), 32'(W + 2));
      acc_prev = acc;
    end
    drain();

    // FullAdder input trace for 0x03 + 0x01
    send(8'h03, 8'h01, 1'b0, 1'b0, acc);
    for (int i = 0; i < W; i++) begin
      int msk;
      msk = (1 << i) - 1;
      check("trace_fa_a", 32'(fa_a), 32'((8'h03 >> i) & 1));
      check("trace_fa_b", 32'(fa_b), 32'((8'h01 >> i) & 1));
      check("trace_fa_c", 32'(fa_c), 32'((((8'h03 & msk) + (8'h01 & msk)) >> i) & 1));
      tick();
    end
    drain();

    // random operands with random backpressure and idle gaps
    rr_rand = 1;
    for (int n = 0; n < 40; n++) begin
      x = W'($urandom);
      y = W'($urandom);
      c = 1'($urandom_range(0, 1));
      send(x, y, c, 1'b0, acc);
      repeat ($urandom_range(0, 3)) tick();
    end
    rr_rand = 0;
    result_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
